// File: rtl/pixie_dma_front_end_v2.sv
// Parametrised Pixie DMA/timing front end: line/frame timing, DMA request,
// frame interrupt, EF flag and frame-buffer write port. Define DMA_ERR_EN for sticky DMA error flags.
module pixie_dma_front_end_v2 #(
  parameter int BYTES_PER_LINE  = 14,
  parameter int LINES_PER_FRAME = 262,
  parameter int ACTIVE_START    = 80,
  parameter int ACTIVE_LINES    = 128,
  parameter int DMA_START       = 1,
  parameter int DMA_BYTES       = 8,
  parameter int INT_LEAD        = 2,
  parameter int EFX_LEAD        = 4,
  parameter int ADDR_W          = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clk_enable,
  input  logic [1:0]        sc,
  input  logic              disp_on,
  input  logic              disp_off,
  input  logic [1:0]        res_mode,
  input  logic [7:0]        data,
  input  logic              err_clr,
  output logic              dmao,
  output logic              int_pixie,
  output logic              efx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_wr_en,
  output logic              err_short,
  output logic              err_extra
);

  localparam int ACTIVE_END = ACTIVE_START + ACTIVE_LINES;
  localparam int HW = (BYTES_PER_LINE > 2) ? $clog2(BYTES_PER_LINE) : 1;
  localparam int VW = (LINES_PER_FRAME > 8) ? $clog2(LINES_PER_FRAME) : 3;
  localparam int BW = $clog2(DMA_BYTES + 1);

  localparam logic [HW-1:0] H_LAST = HW'(BYTES_PER_LINE - 1);
  localparam logic [HW:0]   H_DMA0 = (HW+1)'(DMA_START);
  localparam logic [HW:0]   H_DMA1 = (HW+1)'(DMA_START + DMA_BYTES);
  localparam logic [VW-1:0] V_LAST = VW'(LINES_PER_FRAME - 1);
  localparam logic [VW:0]   V_ACT0 = (VW+1)'(ACTIVE_START);
  localparam logic [VW:0]   V_ACT1 = (VW+1)'(ACTIVE_END);
  localparam logic [VW:0]   V_INT0 = (VW+1)'(ACTIVE_START - INT_LEAD);
  localparam logic [VW:0]   V_EFA0 = (VW+1)'(ACTIVE_START - EFX_LEAD);
  localparam logic [VW:0]   V_EFB0 = (VW+1)'(ACTIVE_END - EFX_LEAD);
  localparam logic [BW-1:0] B_QUOTA = BW'(DMA_BYTES);

  logic              enabled_q, enabled_d;
  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BW-1:0]     bytes_q, bytes_d;
  logic [1:0]        mode_q, mode_d;
  logic              int_q, int_d;
  logic              efx_q, efx_d;
  logic              fetch_q, fetch_d;

  logic              h_wrap, v_wrap;
  logic [VW-1:0]     v_nxt;
  logic [VW:0]       vx;
  logic [2:0]        rel3, rep_mask;
  logic              nxt_active, nxt_fetch, nxt_int, nxt_efx;
  logic              dma_window, dma_cyc, accept;
  logic [BW-1:0]     bytes_inc;

  always_comb begin
    h_wrap = (h_q == H_LAST);
    v_wrap = (v_q == V_LAST);
    v_nxt  = v_wrap ? '0 : v_q + VW'(1);
    vx     = {1'b0, v_nxt};
    rel3   = 3'(vx - V_ACT0);
    case (mode_q)
      2'b00:   rep_mask = 3'b000;
      2'b01:   rep_mask = 3'b001;
      2'b10:   rep_mask = 3'b011;
      default: rep_mask = 3'b111;
    endcase
    // Flags describe the line being entered at the h wrap, not the current one.
    nxt_active = enabled_q && (vx >= V_ACT0) && (vx < V_ACT1);
    nxt_fetch  = nxt_active && ((rel3 & rep_mask) == 3'b000);
    nxt_int    = enabled_q && (vx >= V_INT0) && (vx < V_ACT0);
    nxt_efx    = ((vx >= V_EFA0) && (vx < V_ACT0)) || ((vx >= V_EFB0) && (vx < V_ACT1));

    dma_window = ({1'b0, h_q} >= H_DMA0) && ({1'b0, h_q} < H_DMA1);
    dma_cyc    = clk_enable && enabled_q && (sc == 2'b10);
    accept     = dma_cyc && fetch_q && (bytes_q < B_QUOTA);
    bytes_inc  = bytes_q + BW'(accept);
  end

  always_comb begin
    enabled_d = enabled_q;
    h_d       = h_q;
    v_d       = v_q;
    addr_d    = addr_q;
    bytes_d   = bytes_q;
    mode_d    = mode_q;
    int_d     = int_q;
    efx_d     = efx_q;
    fetch_d   = fetch_q;
    if (clk_enable) begin
      if (disp_on)       enabled_d = 1'b1;
      else if (disp_off) enabled_d = 1'b0;
      h_d     = h_wrap ? '0 : h_q + HW'(1);
      addr_d  = addr_q + ADDR_W'(accept);
      bytes_d = bytes_inc;
      if (h_wrap) begin
        v_d     = v_nxt;
        bytes_d = '0;
        int_d   = nxt_int;
        efx_d   = nxt_efx;
        fetch_d = nxt_fetch;
        if (v_wrap) begin
          mode_d = res_mode;
          addr_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enabled_q <= 1'b0;
      h_q       <= '0;
      v_q       <= '0;
      addr_q    <= '0;
      bytes_q   <= '0;
      mode_q    <= 2'b00;
      int_q     <= 1'b0;
      efx_q     <= 1'b0;
      fetch_q   <= 1'b0;
    end else begin
      enabled_q <= enabled_d;
      h_q       <= h_d;
      v_q       <= v_d;
      addr_q    <= addr_d;
      bytes_q   <= bytes_d;
      mode_q    <= mode_d;
      int_q     <= int_d;
      efx_q     <= efx_d;
      fetch_q   <= fetch_d;
    end
  end

  assign dmao      = enabled_q && fetch_q && dma_window;
  assign int_pixie = int_q;
  assign efx       = efx_q;
  assign mem_wr_en = accept;
  assign mem_addr  = addr_q;
  assign mem_data  = data;

`ifdef DMA_ERR_EN
  logic err_short_q, err_short_d;
  logic err_extra_q, err_extra_d;
  logic short_evt, extra_evt;

  // Set events take priority over a simultaneous clear.
  always_comb begin
    short_evt   = clk_enable && h_wrap && fetch_q && (bytes_inc < B_QUOTA);
    extra_evt   = dma_cyc && !accept;
    err_short_d = err_short_q;
    err_extra_d = err_extra_q;
    if (clk_enable && err_clr) begin
      err_short_d = 1'b0;
      err_extra_d = 1'b0;
    end
    if (short_evt) err_short_d = 1'b1;
    if (extra_evt) err_extra_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_short_q <= 1'b0;
      err_extra_q <= 1'b0;
    end else begin
      err_short_q <= err_short_d;
      err_extra_q <= err_extra_d;
    end
  end

  assign err_short = err_short_q;
  assign err_extra = err_extra_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_short      = 1'b0;
  assign err_extra      = 1'b0;
`endif

endmodule

// File: doc/pixie_dma_front_end_v2.md
Name: pixie_dma_front_end_v2

Overview:
Parametrised successor to the CDP1861 Pixie DMA/timing front end. Generates line and frame timing, the DMA request, the frame interrupt and the EF flag, and writes the CPU DMA bytes into the frame buffer. Adds the following over the fixed 64x128 design:
- Configurable geometry.
- Run-time line-repeat modes: 1, 2, 4 or 8 scanlines per fetched row.
- Per-line DMA byte gating.
- Optional DMA error reporting.
Sits between the 1802 core bus (sc, data) and the video back-end frame memory.

Parameters:
BYTES_PER_LINE, 14, machine cycles per scanline (h counter modulus)
LINES_PER_FRAME, 262, scanlines per frame (v counter modulus)
ACTIVE_START, 80, first active display line
ACTIVE_LINES, 128, active lines; ACTIVE_END = ACTIVE_START+ACTIVE_LINES
DMA_START, 1, first h slot asserting dmao
DMA_BYTES, 8, DMA bytes fetched per fetch line
INT_LEAD, 2, interrupt lines before ACTIVE_START
EFX_LEAD, 4, efx lines before ACTIVE_START and before ACTIVE_END
ADDR_W, 10, frame-buffer address width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
clk_enable  in  1  machine-cycle strobe; all state advances only when high
sc  in  2  1802 state code (00 fetch, 01 execute, 10 DMA, 11 interrupt)
disp_on  in  1  display enable strobe
disp_off  in  1  display disable strobe
res_mode  in  2  line repeat: 00=1, 01=2, 10=4, 11=8 scanlines per row
data  in  8  CPU bus data during DMA
err_clr  in  1  clears sticky error flags (DMA_ERR_EN only)
dmao  out  1  DMA-out request to CPU
int_pixie  out  1  frame interrupt request
efx  out  1  EF flag (border/vblank indicator)
mem_addr  out  ADDR_W  frame-buffer write address
mem_data  out  8  write data (= data)
mem_wr_en  out  1  frame-buffer write strobe
err_short  out  1  sticky: fetch line closed with < DMA_BYTES accepted
err_extra  out  1  sticky: DMA cycle rejected

Behaviour:
- Reset (reset_n low, async): enabled=0; h=0; v=0; addr=0; line byte count=0; latched mode=00; int_pixie=0; efx=0; dmao=0; mem_wr_en=0; err flags=0.
- Enable register: disp_on sets it and disp_off clears it. disp_on wins if both are high. Takes effect at the next clk_enable edge.
- h counts 0..BYTES_PER_LINE-1 and wraps.
- v advances when h wraps, counts 0..LINES_PER_FRAME-1, and wraps.
- res_mode is latched only at frame start (h wraps and v wraps). A mid-frame change has no effect until the next frame.
- Line flags are registered at the h wrap and describe the line being entered:
  - efx = 1 for lines [ACTIVE_START-EFX_LEAD, ACTIVE_START) and [ACTIVE_END-EFX_LEAD, ACTIVE_END). Independent of enable.
  - int_pixie = enabled AND line in [ACTIVE_START-INT_LEAD, ACTIVE_START).
  - active = enabled AND line in [ACTIVE_START, ACTIVE_END).
  - fetch_line = active AND ((line-ACTIVE_START) mod repeat)==0.
- dmao (combinational) = enabled AND fetch_line AND h in [DMA_START, DMA_START+DMA_BYTES). Disabling mid-line drops dmao after the enable register updates.
- DMA accept = clk_enable AND enabled AND sc==10 AND fetch_line AND bytes_this_line < DMA_BYTES.
  - mem_wr_en equals accept (combinational); mem_addr = addr; mem_data = data.
  - On accept, addr increments (wraps at 2^ADDR_W) and bytes_this_line increments.
  - bytes_this_line clears at every h wrap.
- An sc==10 cycle that is not accepted (not a fetch line, or byte quota already reached) produces no write.
- addr resets to 0 at frame start. On repeat lines addr holds, so the back end replicates rows.
- Frame buffer size per frame = DMA_BYTES*ACTIVE_LINES/repeat bytes.

Optional Feature:
DMA_ERR_EN defined:
- err_short sets at the h wrap of a fetch line with bytes_this_line < DMA_BYTES.
- err_extra sets on any non-accepted sc==10 cycle while enabled.
- Both flags are sticky. err_clr clears both. A set event in the same cycle as err_clr wins.

DMA_ERR_EN undefined:
- err_short and err_extra are tied 0; err_clr is ignored; no error logic is instantiated.
- Write gating is identical in both builds.

Test Plan:
- Reset mid-frame (v=100, h=5), release -> all outputs 0; h,v restart from 0; first efx rises entering line 76 (defaults).
- disp_on, mode 00, sc=10 throughout dmao -> dmao high h=1..8 on lines 80..207; 8 writes per line; addr reaches 1024 and wraps to 0; int_pixie high lines 78-79.
- res_mode=10 (x4) latched at frame start -> dmao only on lines 80,84,…,204 (32 fetch lines); final addr 256; toggling res_mode mid-frame has no effect that frame.
- sc=10 held for 10 cycles on a fetch line -> exactly 8 writes; err_extra=1 (DMA_ERR_EN); addr advances by 8.
- Only 5 DMA cycles given on line 80 -> err_short=1 at line end; err_clr -> 0; with DMA_ERR_EN undefined both flags stay 0.
- disp_off asserted on line 150, h=3 -> dmao low from the next clk_enable; no further writes; efx still toggles at lines 204-207.
